dual_port_ram_init: RTL and testbench
=====================================

# dual_port_ram_init

Parametrised simple-dual-port RAM with one write port and one read port, both on a single clock. It adds per-byte write enables, a selectable read-during-write policy, an optional output pipeline register, and a hardware clear engine that fills every word with a constant after reset. It is the general-purpose storage block for buffers and register files, superseding the fixed single-port RAM.

## Interface
- DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8, bits per write-enable lane; NUM_BYTES = DATA_WIDTH/BYTE_WIDTH.
- MEM_LENGTH, 64, number of words; any value ≥ 2, power of two not required; ADDR_WIDTH = $clog2(MEM_LENGTH).
- RDW_MODE, 0, same-address read-during-write policy: 0 = old data, 1 = new data (write-through).
- OUT_REG, 0, 0 = 1-cycle read latency, 1 = extra output register (2-cycle latency).
- INIT_VALUE, 0, DATA_WIDTH-bit word written to every address by the clear engine.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- write_en  in  1  write request.
- byte_en  in  NUM_BYTES  lane i enables bits [i*BYTE_WIDTH +: BYTE_WIDTH].
- write_address  in  ADDR_WIDTH  write word address.
- data_in  in  DATA_WIDTH  write data.
- read_en  in  1  read request.
- read_address  in  ADDR_WIDTH  read word address.
- data_out  out  DATA_WIDTH  read data; holds its last value between reads.
- read_valid  out  1  one-cycle pulse marking new data_out.
- init_busy  out  1  clear engine active; user requests are ignored.

## Operation
- Two states: CLEAR and READY. rst forces CLEAR with clear counter = 0.
- CLEAR: each cycle writes INIT_VALUE to address counter with all lanes enabled, then increments the counter. After writing address MEM_LENGTH-1, transition to READY. While rst stays high, the counter is held at 0.
- rst asserted in any state, including mid-clear, restarts the clear from address 0.
- READY: when write_en=1, lanes with byte_en=1 are updated and the other lanes are preserved. byte_en=0 with write_en=1 is a no-op.
- READY: when read_en=1, mem[read_address] is returned through the read pipeline.
- Read-during-write on the same address with RDW_MODE=1: returned lanes with byte_en=1 come from data_in; other lanes come from memory. With RDW_MODE=0, the pre-write word is returned.
- Out-of-range address (≥ MEM_LENGTH): writes are dropped; reads return 0 with read_valid still pulsed.
- While in CLEAR, write_en and read_en are ignored, and no read_valid is produced.

## Timing
- Reset values: data_out = 0, read_valid = 0, and init_busy = 1 in the cycle after any rst edge sample. Pipeline registers are also cleared.
- Clear duration: init_busy falls exactly MEM_LENGTH cycles after the first edge with rst=0. The first READY cycle accepts requests.
- OUT_REG=0: read_en sampled at edge N gives data_out/read_valid after edge N.
- OUT_REG=1: read_en sampled at edge N gives data_out/read_valid after edge N+1.
- Back-to-back reads sustain one per cycle. read_valid is high for exactly one cycle per accepted read.
- A write at edge N is visible to a different-address read issued at edge N+1. Same-edge same-address behaviour follows RDW_MODE.

## Structure
- Shared package ram_pkg: state enum {CLEAR, READY}, constants RDW_OLD=0 and RDW_NEW=1.
- Sub-module ram_init_ctrl: CLEAR/READY FSM plus clear address counter. Outputs init_busy, clear write enable and clear address. It is muxed ahead of the user write port in the top level.
- The top level contains the memory array, byte-lane write logic, RDW bypass mux and output pipeline.

## Test plan
- Release rst with MEM_LENGTH=64 and INIT_VALUE=32'hDEAD_BEEF → init_busy high for 64 cycles; reads of addresses 0, 31 and 63 return 32'hDEAD_BEEF.
- Write 32'h1122_3344 to address 5, then write 32'hAABB_CCDD with byte_en=4'b0101 → reading address 5 returns 32'h11BB_33DD.
- Same-edge write 32'h0000_00FF and read at address 9 (previously 0): RDW_MODE=0 → data_out=0; RDW_MODE=1 → data_out=32'h0000_00FF.
- OUT_REG=1 with reads of addresses 0..3 on consecutive cycles → read_valid is a 4-cycle train starting 2 cycles later, with data in order.
- Assert rst at clear address 30, then release → init_busy lasts a full MEM_LENGTH more cycles, and writes or reads issued during that time are ignored.
- MEM_LENGTH=48: write 8'h5A to address 50 → dropped; read of address 50 returns 0 with read_valid=1, and address 47 is unchanged.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and constants for the dual-port RAM with hardware clear.
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

endpackage

// File: rtl/ram_init_ctrl.sv
// Clear engine: walks every address once after reset, then hands the
// write port over to the user.
module ram_init_ctrl
  import ram_pkg::*;
#(
  parameter int MEM_LENGTH = 64,
  parameter int ADDR_WIDTH = $clog2(MEM_LENGTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_busy,
  output logic                  clear_en,
  output logic [ADDR_WIDTH-1:0] clear_address
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_LENGTH - 1);

  state_t                  state_reg;
  logic [ADDR_WIDTH-1:0]   count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= CLEAR;
      count_reg <= '0;
    end else begin
      case (state_reg)
        CLEAR: begin
          if (count_reg == LAST_ADDR) begin
            state_reg <= READY;
            count_reg <= '0;
          end else begin
            count_reg <= count_reg + ADDR_WIDTH'(1);
          end
        end
        default: begin
          state_reg <= READY;
        end
      endcase
    end
  end

  assign init_busy     = (state_reg == CLEAR);
  assign clear_en      = (state_reg == CLEAR);
  assign clear_address = count_reg;

endmodule

// File: rtl/dual_port_ram_init.sv
// Simple-dual-port RAM with byte enables, selectable read-during-write
// behaviour, optional output register and a post-reset clear engine.
module dual_port_ram_init
  import ram_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    BYTE_WIDTH = 8,
  parameter int                    MEM_LENGTH = 64,
  parameter int                    RDW_MODE   = 0,
  parameter int                    OUT_REG    = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  localparam int                   NUM_BYTES  = DATA_WIDTH / BYTE_WIDTH,
  localparam int                   ADDR_WIDTH = $clog2(MEM_LENGTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_en,
  input  logic [NUM_BYTES-1:0]  byte_en,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  read_en,
  input  logic [ADDR_WIDTH-1:0] read_address,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  read_valid,
  output logic                  init_busy
);

  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_LENGTH);

  logic [DATA_WIDTH-1:0] mem [MEM_LENGTH];

  logic                  clear_en;
  logic [ADDR_WIDTH-1:0] clear_address;

  ram_init_ctrl #(
    .MEM_LENGTH (MEM_LENGTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ctrl (
    .clk           (clk),
    .rst           (rst),
    .init_busy     (init_busy),
    .clear_en      (clear_en),
    .clear_address (clear_address)
  );

  // User traffic is only honoured once the clear has finished.
  logic user_ok;
  logic wr_in_range;
  logic rd_in_range;
  logic user_wr;
  logic rd_fire;

  assign user_ok     = !init_busy && !rst;
  assign wr_in_range = {1'b0, write_address} < MEM_LIMIT;
  assign rd_in_range = {1'b0, read_address} < MEM_LIMIT;
  assign user_wr     = user_ok && write_en && wr_in_range;
  assign rd_fire     = user_ok && read_en;

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [NUM_BYTES-1:0]  wr_be;
  logic [DATA_WIDTH-1:0] wr_data;

  assign wr_en   = clear_en || user_wr;
  assign wr_addr = clear_en ? clear_address : write_address;
  assign wr_be   = clear_en ? {NUM_BYTES{1'b1}} : byte_en;
  assign wr_data = clear_en ? INIT_VALUE : data_in;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (wr_be[i]) begin
          mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Registered array read; the write-through lanes are captured alongside
  // and merged after the register so the array read stays pure.
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic                  same_addr;
  logic [DATA_WIDTH-1:0] ram_q_reg;
  logic [DATA_WIDTH-1:0] byp_data_reg;
  logic [NUM_BYTES-1:0]  byp_mask_reg;
  logic                  rd_zero_reg;
  logic                  rd_valid_reg;
  logic [DATA_WIDTH-1:0] rd_data;

  assign rd_idx    = rd_in_range ? read_address : '0;
  assign same_addr = (RDW_MODE == RDW_NEW) && user_wr && (write_address == read_address);

  always_ff @(posedge clk) begin
    if (rd_fire) begin
      ram_q_reg <= mem[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byp_data_reg <= '0;
      byp_mask_reg <= '0;
      rd_zero_reg  <= 1'b1;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= rd_fire;
      if (rd_fire) begin
        byp_data_reg <= data_in;
        byp_mask_reg <= same_addr ? byte_en : '0;
        rd_zero_reg  <= !rd_in_range;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
      assign rd_data[gi*BYTE_WIDTH +: BYTE_WIDTH] =
        rd_zero_reg      ? '0 :
        byp_mask_reg[gi] ? byp_data_reg[gi*BYTE_WIDTH +: BYTE_WIDTH]
                         : ram_q_reg[gi*BYTE_WIDTH +: BYTE_WIDTH];
    end
  endgenerate

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] data_out_reg;
      logic                  read_valid_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          data_out_reg   <= '0;
          read_valid_reg <= 1'b0;
        end else begin
          read_valid_reg <= rd_valid_reg;
          if (rd_valid_reg) begin
            data_out_reg <= rd_data;
          end
        end
      end

      assign data_out   = data_out_reg;
      assign read_valid = read_valid_reg;
    end else begin : g_no_out_reg
      assign data_out   = rd_data;
      assign read_valid = rd_valid_reg;
    end
  endgenerate

endmodule

// File: tb/tb_dual_port_ram_init.sv
// Directed bench: two instances share stimulus (A: 64 words, old-data, no
// output reg, init DEADBEEF; B: 48 words, write-through, output reg, init 0).
module tb_dual_port_ram_init;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        write_en = 1'b0;
  logic [3:0]  byte_en = 4'h0;
  logic [5:0]  write_address = '0;
  logic [31:0] data_in = '0;
  logic        read_en = 1'b0;
  logic [5:0]  read_address = '0;

  logic [31:0] data_a, data_b;
  logic        valid_a, valid_b, busy_a, busy_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dual_port_ram_init #(
    .DATA_WIDTH (32), .BYTE_WIDTH (8), .MEM_LENGTH (64),
    .RDW_MODE (0), .OUT_REG (0), .INIT_VALUE (32'hDEAD_BEEF)
  ) dut_a (
    .clk (clk), .rst (rst), .write_en (write_en), .byte_en (byte_en),
    .write_address (write_address), .data_in (data_in), .read_en (read_en),
    .read_address (read_address), .data_out (data_a), .read_valid (valid_a),
    .init_busy (busy_a)
  );

  dual_port_ram_init #(
    .DATA_WIDTH (32), .BYTE_WIDTH (8), .MEM_LENGTH (48),
    .RDW_MODE (1), .OUT_REG (1), .INIT_VALUE (32'h0000_0000)
  ) dut_b (
    .clk (clk), .rst (rst), .write_en (write_en), .byte_en (byte_en),
    .write_address (write_address), .data_in (data_in), .read_en (read_en),
    .read_address (read_address), .data_out (data_b), .read_valid (valid_b),
    .init_busy (busy_b)
  );

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [5:0]  waddr;
    logic [31:0] din;
    logic        re;
    logic [5:0]  raddr;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(logic we, logic [3:0] be, logic [5:0] wa, logic [31:0] d,
                              logic re, logic [5:0] ra, logic [31:0] ea, logic [31:0] eb);
    vec_t v;
    v.we = we; v.be = be; v.waddr = wa; v.din = d;
    v.re = re; v.raddr = ra; v.exp_a = ea; v.exp_b = eb;
    return v;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    write_en = 1'b0; byte_en = 4'h0; read_en = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v, input string name);
    write_en = v.we; byte_en = v.be; write_address = v.waddr; data_in = v.din;
    read_en = v.re; read_address = v.raddr;
    cycle();
    idle();
    chk({name, " valid_a"}, 32'(valid_a), 32'(v.re));
    if (v.re) chk({name, " data_a"}, data_a, v.exp_a);
    chk({name, " valid_b early"}, 32'(valid_b), 32'h0);
    cycle();
    chk({name, " valid_a pulse"}, 32'(valid_a), 32'h0);
    chk({name, " valid_b"}, 32'(valid_b), 32'(v.re));
    if (v.re) chk({name, " data_b"}, data_b, v.exp_b);
    $display("%s: we=%0b be=%b wa=%0d din=%h re=%0b ra=%0d a=%h b=%h",
             name, v.we, v.be, v.waddr, v.din, v.re, v.raddr, data_a, data_b);
  endtask

  initial begin
    int na, nb;

    // Reset state
    repeat (3) cycle();
    chk("rst busy_a", 32'(busy_a), 32'h1);
    chk("rst busy_b", 32'(busy_b), 32'h1);
    chk("rst data_a", data_a, 32'h0);
    chk("rst data_b", data_b, 32'h0);
    chk("rst valid_a", 32'(valid_a), 32'h0);
    chk("rst valid_b", 32'(valid_b), 32'h0);

    // Clear duration after release
    rst = 1'b0;
    na = 0; nb = 0;
    for (int c = 1; c <= 200; c++) begin
      cycle();
      if (!busy_a && na == 0) na = c;
      if (!busy_b && nb == 0) nb = c;
      if (na != 0 && nb != 0) break;
    end
    chk("clear len a", 32'(na), 32'd64);
    chk("clear len b", 32'(nb), 32'd48);
    $display("clear done: a=%0d cycles b=%0d cycles", na, nb);

    vecs[0]  = mk(0, 4'h0, 0,  0,            1, 0,  32'hDEAD_BEEF, 32'h0);
    vecs[1]  = mk(0, 4'h0, 0,  0,            1, 31, 32'hDEAD_BEEF, 32'h0);
    vecs[2]  = mk(0, 4'h0, 0,  0,            1, 63, 32'hDEAD_BEEF, 32'h0);
    vecs[3]  = mk(1, 4'hF, 5,  32'h1122_3344, 0, 0, 32'h0, 32'h0);
    vecs[4]  = mk(1, 4'h5, 5,  32'hAABB_CCDD, 0, 0, 32'h0, 32'h0);
    vecs[5]  = mk(0, 4'h0, 0,  0,            1, 5,  32'h11BB_33DD, 32'h11BB_33DD);
    vecs[6]  = mk(1, 4'h0, 5,  32'hFFFF_FFFF, 0, 0, 32'h0, 32'h0);
    vecs[7]  = mk(0, 4'h0, 0,  0,            1, 5,  32'h11BB_33DD, 32'h11BB_33DD);
    vecs[8]  = mk(1, 4'hF, 9,  32'h0000_00FF, 1, 9, 32'hDEAD_BEEF, 32'h0000_00FF);
    vecs[9]  = mk(0, 4'h0, 0,  0,            1, 9,  32'h0000_00FF, 32'h0000_00FF);
    vecs[10] = mk(1, 4'h2, 9,  32'h1234_5678, 1, 9, 32'h0000_00FF, 32'h0000_56FF);
    vecs[11] = mk(0, 4'h0, 0,  0,            1, 9,  32'h0000_56FF, 32'h0000_56FF);
    vecs[12] = mk(1, 4'hF, 47, 32'hCAFE_F00D, 0, 0, 32'h0, 32'h0);
    vecs[13] = mk(1, 4'h1, 50, 32'h0000_005A, 0, 0, 32'h0, 32'h0);
    vecs[14] = mk(0, 4'h0, 0,  0,            1, 50, 32'hDEAD_BE5A, 32'h0);
    vecs[15] = mk(0, 4'h0, 0,  0,            1, 47, 32'hCAFE_F00D, 32'hCAFE_F00D);

    for (int i = 0; i < 16; i++) begin
      apply_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-to-back reads of 0..3
    for (int i = 0; i < 4; i++) begin
      write_en = 1'b1; byte_en = 4'hF; write_address = 6'(i); data_in = 32'h100 + 32'(i);
      cycle();
    end
    idle();
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        read_en = 1'b1; read_address = 6'(k);
      end else begin
        read_en = 1'b0;
      end
      cycle();
      chk($sformatf("train%0d valid_a", k), 32'(valid_a), 32'(k < 4));
      chk($sformatf("train%0d data_a", k), data_a, 32'h100 + 32'((k < 4) ? k : 3));
      chk($sformatf("train%0d valid_b", k), 32'(valid_b), 32'(k >= 1 && k <= 4));
      if (k >= 1) chk($sformatf("train%0d data_b", k), data_b, 32'h100 + 32'((k <= 4) ? k - 1 : 3));
      $display("train%0d: va=%0b a=%h vb=%0b b=%h", k, valid_a, data_a, valid_b, data_b);
    end
    idle();

    // Write at edge N, read same address at edge N+1
    write_en = 1'b1; byte_en = 4'hF; write_address = 20; data_in = 32'h2020_2020;
    cycle();
    write_en = 1'b0; read_en = 1'b1; read_address = 20;
    cycle();
    idle();
    chk("wr-rd data_a", data_a, 32'h2020_2020);
    cycle();
    chk("wr-rd data_b", data_b, 32'h2020_2020);
    $display("wr-rd: a=%h b=%h", data_a, data_b);

    // Reset mid-clear
    rst = 1'b1;
    cycle();
    chk("rst2 data_a", data_a, 32'h0);
    chk("rst2 data_b", data_b, 32'h0);
    chk("rst2 busy_a", 32'(busy_a), 32'h1);
    rst = 1'b0;
    repeat (30) cycle();
    chk("mid busy_a", 32'(busy_a), 32'h1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    write_en = 1'b1; byte_en = 4'hF; write_address = 1; data_in = 32'h7777_7777;
    read_en = 1'b1; read_address = 1;
    na = 0; nb = 0;
    for (int c = 1; c <= 200; c++) begin
      cycle();
      chk($sformatf("clr%0d valid_a", c), 32'(valid_a), 32'h0);
      chk($sformatf("clr%0d valid_b", c), 32'(valid_b), 32'h0);
      if (!busy_b && nb == 0) begin
        nb = c;
        idle();
      end
      if (!busy_a && na == 0) na = c;
      if (na != 0 && nb != 0) break;
    end
    idle();
    chk("reclear len a", 32'(na), 32'd64);
    chk("reclear len b", 32'(nb), 32'd48);
    $display("reclear done: a=%0d cycles b=%0d cycles", na, nb);

    apply_vec(mk(0, 4'h0, 0, 0, 1, 1,  32'hDEAD_BEEF, 32'h0), "post1");
    apply_vec(mk(0, 4'h0, 0, 0, 1, 20, 32'hDEAD_BEEF, 32'h0), "post20");
    apply_vec(mk(0, 4'h0, 0, 0, 1, 50, 32'hDEAD_BEEF, 32'h0), "post50");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
